// File: rtl/uart_servo_cmd_parser.sv
// uart_servo_cmd_parser: validates SYNC/CMD/DATA/CHK frames from uart_rx and sets the servo pulse width
//   i_clk, i_resetn          clock, asynchronous active-low reset
//   i_rx_valid, i_rx_data    received byte and its one-cycle strobe
//   i_rx_break               line break from uart_rx, aborts a frame in progress
//   o_pwm_width, o_angle     last applied pulse width (cycles) and angle
//   o_frame_ok, o_frame_err  one-cycle accept / reject pulses
//   o_err_code, o_err_count  cause of last reject (0 chk, 1 cmd, 2 range, 3 timeout/break), saturating reject count
module uart_servo_cmd_parser #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned PULSE_MIN      = 27000,
  parameter int unsigned PULSE_STEP     = 150,
  parameter int unsigned ANGLE_MAX      = 180,
  parameter int unsigned TIMEOUT_CYCLES = 270000,
  parameter int unsigned WIDTH_BITS     = 20
) (
  input  logic                  i_clk,
  input  logic                  i_resetn,
  input  logic                  i_rx_valid,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_break,
  output logic [WIDTH_BITS-1:0] o_pwm_width,
  output logic                  o_frame_ok,
  output logic                  o_frame_err,
  output logic [1:0]            o_err_code,
  output logic [7:0]            o_err_count,
  output logic [7:0]            o_angle
);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [WIDTH_BITS-1:0] PMIN = WIDTH_BITS'(PULSE_MIN);
  localparam logic [WIDTH_BITS-1:0] PSTEP = WIDTH_BITS'(PULSE_STEP);
  localparam logic [WIDTH_BITS-1:0] PCENTRE = WIDTH_BITS'(PULSE_MIN + 90 * PULSE_STEP);
  typedef enum logic [2:0] {IDLE, WAIT_CMD, WAIT_DATA, WAIT_CHK, APPLY} state_t;
  state_t state, state_d;
  logic [7:0] cmd, cmd_d, data, data_d, angle_d, count_d, new_angle;
  logic [TW-1:0] tmo, tmo_d;
  logic [WIDTH_BITS-1:0] width_d, new_width;
  logic [1:0] code_d;
  logic ok_d, err_d, cmd_bad, range_bad, apply_ok;
  assign cmd_bad = cmd != 8'h01 && cmd != 8'h02;
  assign range_bad = cmd == 8'h01 && 32'(data) > ANGLE_MAX;
  assign apply_ok = !cmd_bad && !range_bad;
  assign new_angle = cmd == 8'h01 ? data : 8'd90;
  assign new_width = PMIN + WIDTH_BITS'(new_angle) * PSTEP;
  always_comb begin
    state_d = state;
    cmd_d = cmd;
    data_d = data;
    tmo_d = '0;
    ok_d = 1'b0;
    err_d = 1'b0;
    code_d = o_err_code;
    width_d = o_pwm_width;
    angle_d = o_angle;
    if (state != IDLE && i_rx_break) begin
      err_d = 1'b1;
      code_d = 2'd3;
      state_d = IDLE;
    end else if (state == APPLY) begin
      state_d = IDLE;
      ok_d = apply_ok;
      err_d = !apply_ok;
      code_d = cmd_bad ? 2'd1 : range_bad ? 2'd2 : o_err_code;
      width_d = apply_ok ? new_width : o_pwm_width;
      angle_d = apply_ok ? new_angle : o_angle;
    end else if (i_rx_valid) begin
      case (state)
        IDLE: state_d = i_rx_data == SYNC_BYTE ? WAIT_CMD : IDLE;
        WAIT_CMD: begin
          cmd_d = i_rx_data;
          state_d = WAIT_DATA;
        end
        WAIT_DATA: begin
          data_d = i_rx_data;
          state_d = WAIT_CHK;
        end
        default: begin
          err_d = i_rx_data != (cmd ^ data);
          code_d = err_d ? 2'd0 : o_err_code;
          state_d = err_d ? IDLE : APPLY;
        end
      endcase
    end else if (state != IDLE) begin
      // inter-byte gap inside a frame; a valid byte above restarts the count from zero
      err_d = tmo == TLAST;
      code_d = err_d ? 2'd3 : o_err_code;
      state_d = err_d ? IDLE : state;
      tmo_d = err_d ? '0 : tmo + 1'b1;
    end
    count_d = err_d && o_err_count != 8'hFF ? o_err_count + 8'd1 : o_err_count;
  end
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state <= IDLE;
      cmd <= '0;
      data <= '0;
      tmo <= '0;
      o_pwm_width <= PCENTRE;
      o_angle <= 8'd90;
      o_frame_ok <= 1'b0;
      o_frame_err <= 1'b0;
      o_err_code <= 2'd0;
      o_err_count <= 8'd0;
    end else begin
      state <= state_d;
      cmd <= cmd_d;
      data <= data_d;
      tmo <= tmo_d;
      o_pwm_width <= width_d;
      o_angle <= angle_d;
      o_frame_ok <= ok_d;
      o_frame_err <= err_d;
      o_err_code <= code_d;
      o_err_count <= count_d;
    end
  end
endmodule

// File: tb/tb_uart_servo_cmd_parser.sv
// tb_uart_servo_cmd_parser: scoreboard bench for uart_servo_cmd_parser
module tb_uart_servo_cmd_parser;
  localparam int TMO = 40;
  logic clk = 1'b0, rst_n = 1'b0, rx_valid = 1'b0, rx_break = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [19:0] pwm;
  logic ok, err;
  logic [1:0] code;
  logic [7:0] cnt, ang;
  typedef struct {
    logic ok;
    logic [1:0] code;
    logic [19:0] pwm;
    logic [7:0] ang;
    logic [7:0] cnt;
    int due;
  } exp_t;
  exp_t sbq[$];
  exp_t me;
  int cyc = 0, total = 0, passed = 0;
  logic [19:0] m_pwm = 20'd40500;
  logic [7:0] m_ang = 8'd90, m_cnt = 8'd0;
  uart_servo_cmd_parser #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_resetn(rst_n), .i_rx_valid(rx_valid), .i_rx_data(rx_data), .i_rx_break(rx_break),
    .o_pwm_width(pwm), .o_frame_ok(ok), .o_frame_err(err), .o_err_code(code), .o_err_count(cnt), .o_angle(ang)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rst_n && (ok || err)) begin
    total++;
    if (ok && err) $display("FAIL both_pulses ok=%0b err=%0b required not both", ok, err);
    else passed++;
    if (sbq.size() == 0) begin
      total++;
      $display("FAIL unexpected_event ok=%0b err=%0b code=%0d at cyc %0d, required none", ok, err, code, cyc);
    end else begin
      me = sbq.pop_front();
      total++;
      if (ok !== me.ok) $display("FAIL event_kind ok=%0b required %0b", ok, me.ok);
      else passed++;
      if (me.due >= 0) begin
        total++;
        if (cyc != me.due) $display("FAIL latency cyc=%0d required %0d", cyc, me.due);
        else passed++;
      end
      total++;
      if (pwm !== me.pwm) $display("FAIL pwm_width got %0d required %0d", pwm, me.pwm);
      else passed++;
      total++;
      if (ang !== me.ang) $display("FAIL angle got %0d required %0d", ang, me.ang);
      else passed++;
      total++;
      if (cnt !== me.cnt) $display("FAIL err_count got %0d required %0d", cnt, me.cnt);
      else passed++;
      if (!me.ok) begin
        total++;
        if (code !== me.code) $display("FAIL err_code got %0d required %0d", code, me.code);
        else passed++;
      end
    end
  end
  task automatic send_byte(input logic [7:0] b, input int gap, output int s);
    repeat (gap) @(posedge clk);
    @(posedge clk);
    #1 rx_valid = 1'b1;
    rx_data = b;
    s = cyc;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask
  task automatic push_err(input logic [1:0] c, input int due);
    exp_t e;
    m_cnt = m_cnt == 8'hFF ? 8'hFF : m_cnt + 8'd1;
    e.ok = 1'b0; e.code = c; e.pwm = m_pwm; e.ang = m_ang; e.cnt = m_cnt; e.due = due;
    sbq.push_back(e);
  endtask
  task automatic frame(input logic [7:0] c, input logic [7:0] d, input logic [7:0] k, input int gap);
    int s;
    exp_t e;
    send_byte(8'hA5, gap, s);
    send_byte(c, gap, s);
    send_byte(d, gap, s);
    send_byte(k, gap, s);
    if (k != (c ^ d)) push_err(2'd0, s + 1);
    else if (c != 8'h01 && c != 8'h02) push_err(2'd1, s + 2);
    else if (c == 8'h01 && d > 8'd180) push_err(2'd2, s + 2);
    else begin
      m_ang = c == 8'h01 ? d : 8'd90;
      m_pwm = 20'd27000 + 20'(m_ang) * 20'd150;
      e.ok = 1'b1; e.code = 2'd0; e.pwm = m_pwm; e.ang = m_ang; e.cnt = m_cnt; e.due = s + 2;
      sbq.push_back(e);
    end
  endtask
  task automatic drain(input int budget);
    for (int i = 0; i < budget && sbq.size() > 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1 total++;
    if (sbq.size() != 0) $display("FAIL drain_timeout pending=%0d required 0", sbq.size());
    else passed++;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 total++;
    if ({pwm, ang, ok, err, code, cnt} !== {20'd40500, 8'd90, 1'b0, 1'b0, 2'd0, 8'd0})
      $display("FAIL reset_state pwm=%0d ang=%0d ok=%0b err=%0b code=%0d cnt=%0d required 40500 90 0 0 0 0", pwm, ang, ok, err, code, cnt);
    else passed++;
    rst_n = 1'b1;
  endtask
  task automatic test_basic;
    frame(8'h01, 8'h5A, 8'h5B, 2);
    drain(20);
    total++;
    if ({pwm, ang, cnt} !== {20'd40500, 8'd90, 8'd0}) $display("FAIL basic pwm=%0d ang=%0d cnt=%0d required 40500 90 0", pwm, ang, cnt);
    else passed++;
  endtask
  task automatic test_limits;
    frame(8'h01, 8'hB4, 8'hB5, 1);
    drain(20);
    total++;
    if (pwm !== 20'd54000) $display("FAIL max_angle pwm=%0d required 54000", pwm);
    else passed++;
    frame(8'h01, 8'h00, 8'h01, 0);
    drain(20);
    total++;
    if (pwm !== 20'd27000) $display("FAIL min_angle pwm=%0d required 27000", pwm);
    else passed++;
  endtask
  task automatic test_errors;
    frame(8'h01, 8'h5A, 8'h5C, 1);
    drain(20);
    total++;
    if ({code, cnt, pwm} !== {2'd0, 8'd1, 20'd27000}) $display("FAIL chk_err code=%0d cnt=%0d pwm=%0d required 0 1 27000", code, cnt, pwm);
    else passed++;
    frame(8'h01, 8'hB5, 8'hB4, 1);
    drain(20);
    total++;
    if (code !== 2'd2) $display("FAIL range_err code=%0d required 2", code);
    else passed++;
    frame(8'h07, 8'h10, 8'h17, 1);
    drain(20);
    total++;
    if ({code, cnt} !== {2'd1, 8'd3}) $display("FAIL cmd_err code=%0d cnt=%0d required 1 3", code, cnt);
    else passed++;
  endtask
  task automatic test_resync;
    int s;
    send_byte(8'h00, 1, s);
    send_byte(8'hFF, 1, s);
    send_byte(8'h13, 1, s);
    @(posedge clk);
    #1 rx_break = 1'b1;
    @(posedge clk);
    #1 rx_break = 1'b0;
    frame(8'h02, 8'h33, 8'h31, 1);
    drain(20);
    total++;
    if ({pwm, cnt} !== {20'd40500, 8'd3}) $display("FAIL centre pwm=%0d cnt=%0d required 40500 3", pwm, cnt);
    else passed++;
    frame(8'hA5, 8'hA5, 8'h00, 1);
    drain(20);
    total++;
    if (code !== 2'd1) $display("FAIL sync_in_frame code=%0d required 1", code);
    else passed++;
  endtask
  task automatic test_timeout_break;
    int s;
    send_byte(8'hA5, 1, s);
    send_byte(8'h01, 1, s);
    push_err(2'd3, -1);
    drain(TMO + 20);
    total++;
    if (code !== 2'd3) $display("FAIL timeout code=%0d required 3", code);
    else passed++;
    frame(8'h01, 8'h2D, 8'h2C, 1);
    drain(20);
    total++;
    if (pwm !== 20'd33750) $display("FAIL after_timeout pwm=%0d required 33750", pwm);
    else passed++;
    frame(8'h01, 8'h10, 8'h10, 0);
    drain(20);
    send_byte(8'hA5, 1, s);
    push_err(2'd3, -1);
    @(posedge clk);
    #1 rx_break = 1'b1;
    @(posedge clk);
    #1 rx_break = 1'b0;
    drain(20);
    total++;
    if (code !== 2'd3) $display("FAIL break code=%0d required 3", code);
    else passed++;
  endtask
  task automatic test_reset_midframe;
    int s;
    frame(8'h01, 8'hB4, 8'hB5, 1);
    drain(20);
    send_byte(8'hA5, 1, s);
    send_byte(8'h01, 1, s);
    #2 rst_n = 1'b0;
    #1 total++;
    if ({pwm, ang, cnt, ok, err} !== {20'd40500, 8'd90, 8'd0, 1'b0, 1'b0})
      $display("FAIL async_reset pwm=%0d ang=%0d cnt=%0d required 40500 90 0", pwm, ang, cnt);
    else passed++;
    sbq.delete();
    m_pwm = 20'd40500; m_ang = 8'd90; m_cnt = 8'd0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    frame(8'h01, 8'h3C, 8'h3D, 1);
    drain(20);
    total++;
    if (pwm !== 20'd36000) $display("FAIL post_reset_frame pwm=%0d required 36000", pwm);
    else passed++;
  endtask
  task automatic test_back_to_back;
    for (int i = 0; i < 260; i++) frame(8'h01, 8'(i), 8'(i), 0);
    drain(40);
    total++;
    if (cnt !== 8'd255) $display("FAIL saturation cnt=%0d required 255", cnt);
    else passed++;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1);
  end
  initial begin
    test_reset();
    test_basic();
    test_limits();
    test_errors();
    test_resync();
    test_timeout_break();
    test_reset_midframe();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
